// File: rtl/divider_nonrestoring_radix2.sv
// Sequential unsigned radix-2 non-restoring divider with a start/busy/done handshake.
// Each RUN cycle adds or subtracts the divisor depending on the sign of the partial remainder; FIX corrects the remainder.
module divider_nonrestoring_radix2 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [N:0]    a;        // signed partial remainder
    logic [N-1:0]  q;
    logic [N-1:0]  m;
    logic [CW-1:0] count;

    logic [N:0]    a_shift;
    logic [N:0]    a_step;
    logic [N-1:0]  a_fix;
    logic          last_iter;

    // One non-restoring step: shift {A,Q} left, then add or subtract M by the old sign of A.
    always_comb begin
        a_shift   = {a[N-1:0], q[N-1]};
        a_step    = a[N] ? (a_shift + {1'b0, m}) : (a_shift - {1'b0, m});
        a_fix     = a[N-1:0] + m;
        last_iter = (count == CW'(N - 1));
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it holding a value and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? IDLE : RUN;
            RUN:  if (last_iter) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, matching flip-flop behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all datapath registers are plain flops (no memory arrays), so each one is cleared by the async reset; an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a           <= '0;
                        q           <= dividend;
                        m           <= divisor;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor completes on the accept edge with saturated quotient.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a     <= a_step;
                    q     <= {q[N-2:0], ~a_step[N]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    // A negative final remainder is restored by adding M back once.
                    remainder <= a[N] ? a_fix : a[N-1:0];
                    quotient  <= q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_nonrestoring_radix2.sv
// Self-checking bench for divider_nonrestoring_radix2: directed cases, handshake timing, reset abort, random sweep.
// Expected results are queued at accept time and compared when done is seen.
module tb_divider_nonrestoring_radix2;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] quo;
        logic [N-1:0] rem;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int   total;
    int   bad;
    int   done_count;
    exp_t sb[$];

    divider_nonrestoring_radix2 #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a request for the coming edge and queues its reference result.
    task automatic start_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        if (dvs == '0) begin
            e.quo = '1;
            e.rem = dvd;
            e.dbz = 1'b1;
        end else begin
            e.quo = dvd / dvs;
            e.rem = dvd % dvs;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Counts falling edges until done; start is re-raised only on the pulse cycles given.
    task automatic wait_done(input int pa, input int pb, output int lat, output int busy_cycles);
        bit seen;
        lat         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            start    = (lat == pa) || (lat == pb);
            dividend = N'($urandom);
            divisor  = N'($urandom);
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.quo));
                check("remainder", 32'(remainder), 32'(e.rem));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    initial begin
        int lat;
        int bc;
        int dc;
        total      = 0;
        bad        = 0;
        done_count = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        dividend   = '0;
        divisor    = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7: done is observed after the completion edge, N+1 edges past the accept edge.
        start_op(8'd100, 8'd7);
        wait_done(-1, -1, lat, bc);
        check("lat_100_7", 32'(lat), 32'(N + 2));
        check("busy_cycles_100_7", 32'(bc), 32'(N + 1));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        start_op(8'd255, 8'd1);   wait_done(-1, -1, lat, bc);
        start_op(8'd5, 8'd9);     wait_done(-1, -1, lat, bc);
        start_op(8'd255, 8'd255); wait_done(-1, -1, lat, bc);
        start_op(8'd128, 8'd3);   wait_done(-1, -1, lat, bc);

        // Zero divisor completes in the cycle after accept; the next request clears the flag at accept.
        @(negedge clk);
        start_op(8'd42, 8'd0);
        wait_done(-1, -1, lat, bc);
        check("lat_div0", 32'(lat), 32'd1);
        check("busy_div0", 32'(bc), 32'd0);
        @(negedge clk);
        start_op(8'd10, 8'd3);
        @(negedge clk);
        start = 1'b0;
        check("dbz_cleared_at_accept", 32'(div_by_zero), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(-1, -1, lat, bc);

        // Start pulses while busy must be ignored.
        @(negedge clk);
        dc = done_count;
        start_op(8'd100, 8'd7);
        wait_done(3, 5, lat, bc);
        check("lat_with_pulses", 32'(lat), 32'(N + 2));
        repeat (15) @(negedge clk);
        check("single_done", 32'(done_count - dc), 32'd1);
        check("idle_after_pulses", 32'(busy), 32'd0);

        // Back-to-back: new request held in the done cycle is accepted with no gap.
        start_op(8'd100, 8'd7);
        wait_done(-1, -1, lat, bc);
        start_op(8'd200, 8'd13);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_quotient_held", 32'(quotient), 32'd14);
        check("b2b_remainder_held", 32'(remainder), 32'd2);
        wait_done(-1, -1, lat, bc);
        check("b2b_lat", 32'(lat), 32'(N + 1));

        // Asynchronous reset in the middle of RUN aborts the operation silently.
        @(negedge clk);
        start_op(8'd50, 8'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dc = done_count;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_count - dc), 32'd0);
        start_op(8'd77, 8'd5);
        wait_done(-1, -1, lat, bc);
        check("lat_after_abort", 32'(lat), 32'(N + 2));

        // Random sweep against the / and % reference.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start_op(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)));
            wait_done(-1, -1, lat, bc);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
